// File: rtl/rv_alu_pipe_if.sv
// rv_alu_pipe_if: decode-side operands/controls in, bus/redirect/write-back results out
interface rv_alu_pipe_if;
  logic [31:0] i_pc, i_pc_next, i_imm_i, i_imm_j, i_reg1_data, i_reg2_data;
  logic [4:0] i_rd, i_alu_ctrl;
  logic [3:0] i_alu_res;
  logic [2:0] i_funct3, i_res_src;
  logic [1:0] i_op1_src;
  logic i_op2_src, i_reg_write, i_inst_jalr, i_inst_jal, i_inst_branch, i_inst_store;
  logic [31:0] o_wdata, o_alu_result, o_add, o_pc_next, o_pc_target;
  logic [4:0] o_rd;
  logic [3:0] o_wsel;
  logic [2:0] o_funct3, o_res_src;
  logic o_reg_write, o_store, o_pc_select;
  modport slave (
    input i_pc, i_pc_next, i_imm_i, i_imm_j, i_reg1_data, i_reg2_data, i_rd, i_alu_ctrl,
          i_alu_res, i_funct3, i_res_src, i_op1_src, i_op2_src, i_reg_write,
          i_inst_jalr, i_inst_jal, i_inst_branch, i_inst_store,
    output o_wdata, o_alu_result, o_add, o_pc_next, o_pc_target, o_rd, o_wsel,
           o_funct3, o_res_src, o_reg_write, o_store, o_pc_select
  );
  modport master (
    output i_pc, i_pc_next, i_imm_i, i_imm_j, i_reg1_data, i_reg2_data, i_rd, i_alu_ctrl,
           i_alu_res, i_funct3, i_res_src, i_op1_src, i_op2_src, i_reg_write,
           i_inst_jalr, i_inst_jal, i_inst_branch, i_inst_store,
    input o_wdata, o_alu_result, o_add, o_pc_next, o_pc_target, o_rd, o_wsel,
          o_funct3, o_res_src, o_reg_write, o_store, o_pc_select
  );
endinterface

// File: rtl/rv_alu_pipe.sv
// rv_alu_pipe: three-stage RV32I execute pipeline (operands, ALU/branch, result/store format)
module rv_alu_pipe (
  input  logic           i_clk,
  input  logic           i_reset_n,
  rv_alu_pipe_if.slave   bus
);
  typedef struct packed {
    logic [31:0] op1, op2, target, pc_next, rs2;
    logic [4:0]  rd, alu_ctrl;
    logic [3:0]  alu_res;
    logic [2:0]  funct3, res_src;
    logic        jal_jalr, reg_write, store, branch;
  } s1_t;
  typedef struct packed {
    logic [31:0] add, lgc, shift, target, pc_next, rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_res;
    logic [2:0]  funct3, res_src;
    logic        cmp, pc_select, reg_write, store;
  } s2_t;
  s1_t s1, s1_d;
  s2_t s2, s2_d;
  logic [4:0]  shamt;
  logic [31:0] sra, res, wdata;
  logic [3:0]  wsel;
  logic        eq, lts, ltu;
  always_comb begin
    s1_d           = '0;
    s1_d.op1       = bus.i_op1_src[1] ? '0 : bus.i_op1_src[0] ? bus.i_pc : bus.i_reg1_data;
    s1_d.op2       = bus.i_op2_src ? bus.i_imm_i : bus.i_reg2_data;
    s1_d.target    = ((bus.i_inst_jalr ? bus.i_reg1_data : bus.i_pc) + bus.i_imm_j) & ~{31'b0, bus.i_inst_jalr};
    s1_d.pc_next   = bus.i_pc_next;
    s1_d.rs2       = bus.i_reg2_data;
    s1_d.rd        = bus.i_rd;
    s1_d.alu_ctrl  = bus.i_alu_ctrl;
    s1_d.alu_res   = bus.i_alu_res;
    s1_d.funct3    = bus.i_funct3;
    s1_d.res_src   = bus.i_res_src;
    s1_d.jal_jalr  = bus.i_inst_jal | bus.i_inst_jalr;
    s1_d.reg_write = bus.i_reg_write;
    s1_d.store     = bus.i_inst_store;
    s1_d.branch    = bus.i_inst_branch;
  end
  // the signed shift sits in its own signal so the ternary below cannot strip its signedness
  assign shamt = s1.op2[4:0];
  assign sra   = $signed(s1.op1) >>> shamt;
  assign eq    = s1.op1 == s1.op2;
  assign lts   = $signed(s1.op1) < $signed(s1.op2);
  assign ltu   = s1.op1 < s1.op2;
  always_comb begin
    s2_d           = '0;
    s2_d.add       = s1.alu_ctrl[0] ? s1.op1 - s1.op2 : s1.op1 + s1.op2;
    s2_d.lgc       = s1.alu_ctrl[4:3] == 2'b00 ? s1.op1 ^ s1.op2 :
                     s1.alu_ctrl[4:3] == 2'b01 ? s1.op1 | s1.op2 : s1.op1 & s1.op2;
    s2_d.shift     = !s1.alu_ctrl[1] ? s1.op1 << shamt : s1.alu_ctrl[2] ? sra : s1.op1 >> shamt;
    s2_d.cmp       = s1.funct3 == 3'b000 ? eq :
                     s1.funct3 == 3'b001 ? !eq :
                     (s1.funct3 == 3'b010 || s1.funct3 == 3'b100) ? lts :
                     s1.funct3 == 3'b101 ? !lts :
                     (s1.funct3 == 3'b011 || s1.funct3 == 3'b110) ? ltu : !ltu;
    s2_d.pc_select = s1.jal_jalr | (s1.branch & s2_d.cmp);
    s2_d.target    = s1.target;
    s2_d.pc_next   = s1.pc_next;
    s2_d.rs2       = s1.rs2;
    s2_d.rd        = s1.rd;
    s2_d.alu_res   = s1.alu_res;
    s2_d.funct3    = s1.funct3;
    s2_d.res_src   = s1.res_src;
    s2_d.reg_write = s1.reg_write;
    s2_d.store     = s1.store;
  end
  assign res   = s2.alu_res[0] ? s2.add : s2.alu_res[1] ? s2.lgc : s2.alu_res[2] ? s2.shift :
                 s2.alu_res[3] ? {31'b0, s2.cmp} : '0;
  assign wdata = s2.funct3[1] ? s2.rs2 : s2.funct3[0] ? {2{s2.rs2[15:0]}} : {4{s2.rs2[7:0]}};
  assign wsel  = s2.funct3[1] ? 4'b1111 : s2.funct3[0] ? (s2.add[1] ? 4'b1100 : 4'b0011) :
                 4'b0001 << s2.add[1:0];
  always_ff @(posedge i_clk) begin
    s1 <= i_reset_n ? s1_d : '0;
    s2 <= i_reset_n ? s2_d : '0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_wdata      <= '0;
      bus.o_wsel       <= '0;
      bus.o_funct3     <= '0;
      bus.o_alu_result <= '0;
      bus.o_add        <= '0;
      bus.o_reg_write  <= 1'b0;
      bus.o_store      <= 1'b0;
      bus.o_rd         <= '0;
      bus.o_res_src    <= '0;
      bus.o_pc_next    <= '0;
      bus.o_pc_select  <= 1'b0;
      bus.o_pc_target  <= '0;
    end else begin
      bus.o_wdata      <= wdata;
      bus.o_wsel       <= wsel;
      bus.o_funct3     <= s2.funct3;
      bus.o_alu_result <= res;
      bus.o_add        <= s2.add;
      bus.o_reg_write  <= s2.reg_write;
      bus.o_store      <= s2.store;
      bus.o_rd         <= s2.rd;
      bus.o_res_src    <= s2.res_src;
      bus.o_pc_next    <= s2.pc_next;
      bus.o_pc_select  <= s2.pc_select;
      bus.o_pc_target  <= s2.target;
    end
  end
endmodule

// File: tb/tb_rv_alu_pipe.sv
// tb_rv_alu_pipe: directed vectors for the 3-stage execute pipeline
module tb_rv_alu_pipe;
  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  rv_alu_pipe_if bus();
  rv_alu_pipe dut (.i_clk(i_clk), .i_reset_n(rst_n), .bus(bus.slave));
  always #5 i_clk = ~i_clk;
  task automatic clear_in();
    bus.i_pc = '0; bus.i_pc_next = '0; bus.i_imm_i = '0; bus.i_imm_j = '0;
    bus.i_reg1_data = '0; bus.i_reg2_data = '0; bus.i_rd = '0; bus.i_alu_ctrl = '0;
    bus.i_alu_res = '0; bus.i_funct3 = '0; bus.i_res_src = '0; bus.i_op1_src = '0;
    bus.i_op2_src = 1'b0; bus.i_reg_write = 1'b0; bus.i_inst_jalr = 1'b0;
    bus.i_inst_jal = 1'b0; bus.i_inst_branch = 1'b0; bus.i_inst_store = 1'b0;
  endtask
  task automatic edges(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask
  task automatic load_jal();
    clear_in();
    bus.i_inst_jal = 1'b1; bus.i_pc = 32'h200; bus.i_imm_j = 32'h40; bus.i_pc_next = 32'h204;
    bus.i_rd = 5'd1; bus.i_res_src = 3'b010; bus.i_reg_write = 1'b1;
  endtask
  task automatic test_reset();
    load_jal();
    edges(2);
    tests++; if ({bus.o_pc_select, bus.o_pc_target, bus.o_pc_next, bus.o_rd, bus.o_reg_write, bus.o_res_src} !== '0) begin fails++; $display("FAIL reset_state: got %h/%h/%h required 0", bus.o_pc_select, bus.o_pc_target, bus.o_pc_next); end
    tests++; if ({bus.o_wdata, bus.o_wsel, bus.o_funct3, bus.o_alu_result, bus.o_add, bus.o_store} !== '0) begin fails++; $display("FAIL reset_data: got %h %h %h required 0", bus.o_wdata, bus.o_alu_result, bus.o_add); end
    rst_n = 1'b1;
    edges(3);
    tests++; if ({bus.o_pc_select, bus.o_pc_target} !== {1'b1, 32'h240}) begin fails++; $display("FAIL jal_target: got %b %h required 1 00000240", bus.o_pc_select, bus.o_pc_target); end
    tests++; if ({bus.o_pc_next, bus.o_rd, bus.o_res_src, bus.o_reg_write} !== {32'h204, 5'd1, 3'b010, 1'b1}) begin fails++; $display("FAIL jal_wb: got %h %h %b %b", bus.o_pc_next, bus.o_rd, bus.o_res_src, bus.o_reg_write); end
    rst_n = 1'b0;
    edges(1);
    tests++; if ({bus.o_pc_select, bus.o_pc_target, bus.o_pc_next, bus.o_rd, bus.o_reg_write, bus.o_res_src} !== '0) begin fails++; $display("FAIL reset_mid: got %b %h %h required 0", bus.o_pc_select, bus.o_pc_target, bus.o_pc_next); end
    rst_n = 1'b1;
    edges(2);
    tests++; if ({bus.o_pc_select, bus.o_pc_target} !== '0) begin fails++; $display("FAIL refill_early: got %b %h required 0 00000000", bus.o_pc_select, bus.o_pc_target); end
    edges(1);
    tests++; if ({bus.o_pc_select, bus.o_pc_target, bus.o_pc_next} !== {1'b1, 32'h240, 32'h204}) begin fails++; $display("FAIL refill: got %b %h %h required 1 00000240 00000204", bus.o_pc_select, bus.o_pc_target, bus.o_pc_next); end
  endtask
  task automatic test_add();
    clear_in();
    bus.i_reg1_data = 32'h7FFFFFFF; bus.i_reg2_data = 32'h1; bus.i_alu_res = 4'b0001;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'h80000000) begin fails++; $display("FAIL add_res: got %h required 80000000", bus.o_alu_result); end
    tests++; if (bus.o_add !== 32'h80000000) begin fails++; $display("FAIL add_addr: got %h required 80000000", bus.o_add); end
    tests++; if (bus.o_pc_select !== 1'b0) begin fails++; $display("FAIL add_nosel: got %b required 0", bus.o_pc_select); end
    bus.i_reg1_data = 32'h5; bus.i_reg2_data = 32'h7; bus.i_alu_ctrl = 5'b00001;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_res: got %h required fffffffe", bus.o_alu_result); end
    clear_in();
    bus.i_op1_src = 2'b01; bus.i_pc = 32'h1000; bus.i_op2_src = 1'b1; bus.i_imm_i = 32'h10; bus.i_alu_res = 4'b0001; bus.i_reg1_data = 32'hDEAD0000;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'h1010) begin fails++; $display("FAIL auipc: got %h required 00001010", bus.o_alu_result); end
    bus.i_op1_src = 2'b10; bus.i_imm_i = 32'h12345000;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'h12345000) begin fails++; $display("FAIL lui: got %h required 12345000", bus.o_alu_result); end
  endtask
  task automatic test_logic();
    logic [4:0]  ctrl [4] = '{5'b00000, 5'b01000, 5'b10000, 5'b11000};
    logic [31:0] exp  [4] = '{32'hFF000FF0, 32'hFFF00FFF, 32'h00F0000F, 32'h00F0000F};
    clear_in();
    bus.i_reg1_data = 32'hF0F000FF; bus.i_reg2_data = 32'h0FF00F0F; bus.i_alu_res = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      bus.i_alu_ctrl = ctrl[i];
      edges(3);
      tests++; if (bus.o_alu_result !== exp[i]) begin fails++; $display("FAIL logic_%0d: got %h required %h", i, bus.o_alu_result, exp[i]); end
    end
  endtask
  task automatic test_shift();
    logic [4:0]  ctrl [4] = '{5'b00110, 5'b00010, 5'b00000, 5'b00110};
    logic [31:0] imm  [4] = '{32'h4, 32'h4, 32'h4, 32'h24};
    logic [31:0] exp  [4] = '{32'hF8000001, 32'h08000001, 32'h00000100, 32'hF8000001};
    clear_in();
    bus.i_reg1_data = 32'h80000010; bus.i_op2_src = 1'b1; bus.i_alu_res = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      bus.i_alu_ctrl = ctrl[i]; bus.i_imm_i = imm[i];
      edges(3);
      tests++; if (bus.o_alu_result !== exp[i]) begin fails++; $display("FAIL shift_%0d: got %h required %h", i, bus.o_alu_result, exp[i]); end
    end
  endtask
  task automatic test_branch();
    logic [2:0]  f3  [6] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b000, 3'b001};
    logic [31:0] r2  [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        sel [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clear_in();
    bus.i_reg1_data = 32'hFFFFFFFF; bus.i_inst_branch = 1'b1; bus.i_pc = 32'h100; bus.i_imm_j = 32'h20;
    for (int i = 0; i < 6; i++) begin
      bus.i_funct3 = f3[i]; bus.i_reg2_data = r2[i];
      edges(3);
      tests++; if ({bus.o_pc_select, bus.o_pc_target, bus.o_funct3} !== {sel[i], 32'h120, f3[i]}) begin fails++; $display("FAIL branch_%0d: got %b %h %b required %b 00000120 %b", i, bus.o_pc_select, bus.o_pc_target, bus.o_funct3, sel[i], f3[i]); end
    end
    clear_in();
    bus.i_reg1_data = 32'hFFFFFFFF; bus.i_reg2_data = 32'h1; bus.i_alu_res = 4'b1000; bus.i_funct3 = 3'b010;
    edges(3);
    tests++; if ({bus.o_alu_result, bus.o_pc_select} !== {32'h1, 1'b0}) begin fails++; $display("FAIL slt: got %h %b required 00000001 0", bus.o_alu_result, bus.o_pc_select); end
    bus.i_funct3 = 3'b011;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'h0) begin fails++; $display("FAIL sltu: got %h required 00000000", bus.o_alu_result); end
    bus.i_alu_res = 4'b0000;
    edges(3);
    tests++; if (bus.o_alu_result !== 32'h0) begin fails++; $display("FAIL nores: got %h required 00000000", bus.o_alu_result); end
  endtask
  task automatic test_jalr();
    clear_in();
    bus.i_reg1_data = 32'h1003; bus.i_imm_j = 32'h2; bus.i_inst_jalr = 1'b1; bus.i_pc_next = 32'h44; bus.i_pc = 32'h500;
    edges(3);
    tests++; if ({bus.o_pc_select, bus.o_pc_target, bus.o_pc_next} !== {1'b1, 32'h1004, 32'h44}) begin fails++; $display("FAIL jalr: got %b %h %h required 1 00001004 00000044", bus.o_pc_select, bus.o_pc_target, bus.o_pc_next); end
  endtask
  task automatic test_store();
    logic [2:0]  f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] ad [4] = '{32'h2002, 32'h2002, 32'h2000, 32'h2003};
    logic [31:0] wd [4] = '{32'hABABABAB, 32'h56AB56AB, 32'h123456AB, 32'hABABABAB};
    logic [3:0]  ws [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b1000};
    clear_in();
    bus.i_op2_src = 1'b1; bus.i_alu_res = 4'b0001; bus.i_inst_store = 1'b1; bus.i_reg2_data = 32'h123456AB;
    for (int i = 0; i < 4; i++) begin
      bus.i_funct3 = f3[i]; bus.i_reg1_data = ad[i];
      edges(3);
      tests++; if ({bus.o_add, bus.o_wdata, bus.o_wsel, bus.o_store} !== {ad[i], wd[i], ws[i], 1'b1}) begin fails++; $display("FAIL store_%0d: got %h %h %b %b required %h %h %b 1", i, bus.o_add, bus.o_wdata, bus.o_wsel, bus.o_store, ad[i], wd[i], ws[i]); end
    end
  endtask
  task automatic test_back_to_back();
    clear_in();
    bus.i_alu_res = 4'b0001;
    bus.i_reg1_data = 32'h1; bus.i_reg2_data = 32'h2; bus.i_rd = 5'd1;
    edges(1);
    bus.i_reg1_data = 32'hA; bus.i_reg2_data = 32'h3; bus.i_alu_ctrl = 5'b00001; bus.i_rd = 5'd2;
    edges(1);
    bus.i_reg1_data = 32'hFFFFFFFF; bus.i_reg2_data = 32'h1; bus.i_alu_ctrl = 5'b00000; bus.i_rd = 5'd3;
    edges(1);
    tests++; if ({bus.o_alu_result, bus.o_rd} !== {32'h3, 5'd1}) begin fails++; $display("FAIL b2b_0: got %h %0d required 00000003 1", bus.o_alu_result, bus.o_rd); end
    edges(1);
    tests++; if ({bus.o_alu_result, bus.o_rd} !== {32'h7, 5'd2}) begin fails++; $display("FAIL b2b_1: got %h %0d required 00000007 2", bus.o_alu_result, bus.o_rd); end
    edges(1);
    tests++; if ({bus.o_alu_result, bus.o_rd} !== {32'h0, 5'd3}) begin fails++; $display("FAIL b2b_2: got %h %0d required 00000000 3", bus.o_alu_result, bus.o_rd); end
  endtask
  initial begin
    clear_in();
    test_reset();
    test_add();
    test_logic();
    test_shift();
    test_branch();
    test_jalr();
    test_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
